// File: rtl/sobel_scan_sequencer.sv
// sobel_scan_sequencer: column-strip 3x3 window scan that feeds a Sobel engine from frame memory
module sobel_scan_sequencer #(
   parameter int PIXEL_WIDTH = 8,
   parameter int DIM_BITS    = 8,
   parameter int ADDR_BITS   = 16
) (
   input  logic                   clk_i,
   input  logic                   nreset_i,
   input  logic                   start_i,
   input  logic [DIM_BITS-1:0]    img_width_i,
   input  logic [DIM_BITS-1:0]    img_height_i,
   output logic                   mem_req_o,
   output logic [ADDR_BITS-1:0]   mem_addr_o,
   input  logic                   mem_rvalid_i,
   input  logic [PIXEL_WIDTH-1:0] mem_rdata_i,
   output logic                   start_sobel_o,
   output logic [PIXEL_WIDTH-1:0] px_o,
   output logic                   px_rdy_o,
   input  logic [PIXEL_WIDTH-1:0] sobel_px_i,
   input  logic                   sobel_rdy_i,
   output logic [PIXEL_WIDTH-1:0] res_px_o,
   output logic [ADDR_BITS-1:0]   res_addr_o,
   output logic                   res_valid_o,
   output logic                   busy_o,
   output logic                   done_o
);
   typedef enum logic [2:0] {IDLE, LOAD_FIRST, LOAD_NEXT, WAIT_RES, STRIP_GAP, DONE} state_t;
   state_t                 state;
   logic [DIM_BITS-1:0]    w, h, x, y;
   logic [3:0]             cnt;
   logic                   pend, gap, last_px, dims_ok;
   logic [1:0]             row_off, col_off;
   logic [ADDR_BITS-1:0]   rd_addr, res_addr_nxt;

   // window-relative pixel position of the next read and the resulting addresses
   always_comb begin
      row_off      = (state == LOAD_NEXT) ? 2'd2 : (cnt < 4'd3) ? 2'd0 : (cnt < 4'd6) ? 2'd1 : 2'd2;
      col_off      = (state == LOAD_NEXT) ? cnt[1:0] : 2'(cnt - {1'b0, row_off, 1'b0} - {2'b00, row_off});
      rd_addr      = (ADDR_BITS'(y) + ADDR_BITS'(row_off)) * ADDR_BITS'(w) + ADDR_BITS'(x) + ADDR_BITS'(col_off);
      res_addr_nxt = (ADDR_BITS'(y) + ADDR_BITS'(1)) * ADDR_BITS'(w) + ADDR_BITS'(x) + ADDR_BITS'(1);
      last_px      = (state == LOAD_NEXT) ? (cnt == 4'd2) : (cnt == 4'd8);
      dims_ok      = (img_width_i >= DIM_BITS'(3)) && (img_height_i >= DIM_BITS'(3));
   end

   // scan FSM: one read in flight at a time, pixels forwarded the cycle after they return
   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i) begin
         state         <= IDLE;
         w             <= '0;
         h             <= '0;
         x             <= '0;
         y             <= '0;
         cnt           <= '0;
         pend          <= 1'b0;
         gap           <= 1'b0;
         mem_req_o     <= 1'b0;
         mem_addr_o    <= '0;
         start_sobel_o <= 1'b0;
         px_o          <= '0;
         px_rdy_o      <= 1'b0;
         res_px_o      <= '0;
         res_addr_o    <= '0;
         res_valid_o   <= 1'b0;
         busy_o        <= 1'b0;
         done_o        <= 1'b0;
      end else begin
         mem_req_o   <= 1'b0;
         px_rdy_o    <= 1'b0;
         res_valid_o <= 1'b0;
         done_o      <= 1'b0;
         if (pend && mem_rvalid_i) begin
            px_o     <= mem_rdata_i;
            px_rdy_o <= 1'b1;
            pend     <= 1'b0;
         end
         case (state)
            IDLE: if (start_i) begin
               w      <= img_width_i;
               h      <= img_height_i;
               x      <= '0;
               y      <= '0;
               cnt    <= '0;
               busy_o <= 1'b1;
               if (dims_ok) begin
                  state         <= LOAD_FIRST;
                  start_sobel_o <= 1'b1;
               end else begin
                  state  <= DONE;
                  done_o <= 1'b1;
               end
            end
            LOAD_FIRST, LOAD_NEXT: if (!pend) begin
               mem_req_o  <= 1'b1;
               mem_addr_o <= rd_addr;
               pend       <= 1'b1;
            end else if (mem_rvalid_i) begin
               cnt <= last_px ? 4'd0 : cnt + 4'd1;
               if (last_px) state <= WAIT_RES;
            end
            WAIT_RES: if (sobel_rdy_i) begin
               res_px_o    <= sobel_px_i;
               res_addr_o  <= res_addr_nxt;
               res_valid_o <= 1'b1;
               if (y != h - DIM_BITS'(3)) begin
                  y     <= y + DIM_BITS'(1);
                  state <= LOAD_NEXT;
               end else if (x != w - DIM_BITS'(3)) begin
                  state         <= STRIP_GAP;
                  start_sobel_o <= 1'b0;
                  gap           <= 1'b0;
               end else begin
                  state         <= DONE;
                  start_sobel_o <= 1'b0;
                  done_o        <= 1'b1;
               end
            end
            STRIP_GAP: if (gap) begin
               x             <= x + DIM_BITS'(1);
               y             <= '0;
               state         <= LOAD_FIRST;
               start_sobel_o <= 1'b1;
            end else begin
               gap <= 1'b1;
            end
            DONE: begin
               state  <= IDLE;
               busy_o <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sobel_scan_sequencer.sv
// tb_sobel_scan_sequencer: random-latency memory and window-engine models against a frame-level scan reference
module tb_sobel_scan_sequencer;
   logic        clk = 1'b0, nreset = 1'b0, start = 1'b0;
   logic [7:0]  iw = '0, ih = '0;
   logic        mem_req, mem_rvalid = 1'b0, start_sobel, px_rdy, sobel_rdy = 1'b0, res_valid, busy, done;
   logic [15:0] mem_addr, res_addr;
   logic [7:0]  mem_rdata = '0, px, sobel_px = '0, res_px;

   sobel_scan_sequencer dut (
      .clk_i(clk), .nreset_i(nreset), .start_i(start), .img_width_i(iw), .img_height_i(ih),
      .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
      .start_sobel_o(start_sobel), .px_o(px), .px_rdy_o(px_rdy), .sobel_px_i(sobel_px), .sobel_rdy_i(sobel_rdy),
      .res_px_o(res_px), .res_addr_o(res_addr), .res_valid_o(res_valid), .busy_o(busy), .done_o(done)
   );

   always #5 clk = ~clk;

   int n_checks = 0, n_fail = 0;
   logic [7:0] img [0:1023];
   int exp_addr[$], exp_res_addr[$], exp_res_px[$], strip_px[$];
   int win_k = 0, eng_delay = 0, mem_cnt = 0, px_count = 0, done_count = 0, gap_len = 0, exp_px_total = 0;
   bit eng_busy = 0, mem_pend = 0, real_rv = 0, saw_high = 0;
   logic [7:0] mem_data = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int sobel(input int p[9]);
      int gx, gy, m;
      gx = p[2] + 2 * p[5] + p[8] - p[0] - 2 * p[3] - p[6];
      gy = p[6] + 2 * p[7] + p[8] - p[0] - 2 * p[1] - p[2];
      m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
      return m > 255 ? 255 : m;
   endfunction

   // memory, window engine and output monitors, all sampled mid-cycle
   always @(negedge clk) begin : mon
      int p[9];
      if (mem_req) begin
         check("one_outstanding", {31'd0, mem_pend || real_rv}, 0);
         if (exp_addr.size() == 0) check("extra_req", 1, 0);
         else check("rd_addr", {16'd0, mem_addr}, exp_addr.pop_front());
      end
      real_rv = 0;
      mem_rvalid = 1'b0;
      mem_rdata = 8'($urandom);
      if (mem_pend) begin
         mem_cnt--;
         if (mem_cnt == 0) begin
            mem_pend = 0;
            real_rv = 1;
            mem_rvalid = 1'b1;
            mem_rdata = mem_data;
         end
      end else if (!mem_req && $urandom_range(0, 7) == 0) mem_rvalid = 1'b1;
      if (mem_req) begin
         mem_pend = 1;
         mem_cnt = $urandom_range(1, 5);
         mem_data = img[mem_addr];
      end
      if (!start_sobel) begin
         strip_px.delete();
         win_k = 0;
         eng_busy = 0;
      end
      if (px_rdy) begin
         px_count++;
         strip_px.push_back(int'(px));
      end
      sobel_rdy = 1'b0;
      sobel_px = 8'($urandom);
      if (!start_sobel && $urandom_range(0, 3) == 0) sobel_rdy = 1'b1;
      else if (start_sobel) begin
         if (!eng_busy && strip_px.size() >= 9 + 3 * win_k) begin
            eng_busy = 1;
            eng_delay = $urandom_range(0, 2);
         end
         if (eng_busy) begin
            if (eng_delay == 0) begin
               for (int i = 0; i < 9; i++) p[i] = strip_px[3 * win_k + i];
               sobel_rdy = 1'b1;
               sobel_px = 8'(sobel(p));
               win_k++;
               eng_busy = 0;
            end else eng_delay--;
         end
      end
      if (res_valid) begin
         if (exp_res_addr.size() == 0) check("extra_result", 1, 0);
         else begin
            check("res_addr", {16'd0, res_addr}, exp_res_addr.pop_front());
            check("res_px", {24'd0, res_px}, exp_res_px.pop_front());
         end
      end
      if (done) done_count++;
      if (start_sobel) begin
         if (saw_high && gap_len > 0) check("strip_gap_len", gap_len, 2);
         gap_len = 0;
         saw_high = 1;
      end else if (saw_high && busy) gap_len++;
   end

   task automatic build_frame(input int w, input int h);
      int p[9];
      exp_addr.delete();
      exp_res_addr.delete();
      exp_res_px.delete();
      for (int i = 0; i < w * h; i++) img[i] = 8'($urandom);
      if (w >= 3 && h >= 3)
         for (int x = 0; x <= w - 3; x++) begin
            for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) exp_addr.push_back(r * w + x + c);
            for (int y = 1; y <= h - 3; y++) for (int c = 0; c < 3; c++) exp_addr.push_back((y + 2) * w + x + c);
            for (int y = 0; y <= h - 3; y++) begin
               for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) p[r * 3 + c] = int'(img[(y + r) * w + x + c]);
               exp_res_addr.push_back((y + 1) * w + x + 1);
               exp_res_px.push_back(sobel(p));
            end
         end
      exp_px_total = exp_addr.size();
      px_count = 0;
      done_count = 0;
      saw_high = 0;
      gap_len = 0;
      @(negedge clk);
      start = 1'b1;
      iw = 8'(w);
      ih = 8'(h);
      @(negedge clk);
      start = 1'b0;
      iw = 8'($urandom);
      ih = 8'($urandom);
   endtask

   task automatic run_frame(input int w, input int h);
      int n;
      build_frame(w, h);
      check("busy_after_start", {31'd0, busy}, 1);
      n = 1;
      while (!done && n < 20000) begin
         @(negedge clk);
         n++;
         start = (n == 20);
         iw = 8'd3;
         ih = 8'd3;
      end
      start = 1'b0;
      check("done_seen", {31'd0, done}, 1);
      if (w < 3 || h < 3) check("small_done_latency", {31'd0, n <= 2}, 1);
      @(negedge clk);
      check("done_single", {31'd0, done}, 0);
      check("busy_idle", {31'd0, busy}, 0);
      check("start_sobel_idle", {31'd0, start_sobel}, 0);
      check("done_count", done_count, 1);
      check("px_count", px_count, exp_px_total);
      check("reads_left", exp_addr.size(), 0);
      check("results_left", exp_res_addr.size(), 0);
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_bits"}, {24'd0, mem_req, start_sobel, px_rdy, res_valid, busy, done, 2'b00}, 0);
      check({tag, "_mem_addr"}, {16'd0, mem_addr}, 0);
      check({tag, "_px"}, {24'd0, px}, 0);
      check({tag, "_res_px"}, {24'd0, res_px}, 0);
      check({tag, "_res_addr"}, {16'd0, res_addr}, 0);
   endtask

   initial begin
      int n, px_before;
      repeat (3) @(negedge clk);
      check_zero_outputs("reset");
      nreset = 1'b1;
      repeat (2) @(negedge clk);
      run_frame(3, 3);
      run_frame(4, 3);
      run_frame(3, 4);
      run_frame(2, 5);
      run_frame(5, 5);
      build_frame(5, 5);
      n = 0;
      while (exp_addr.size() > exp_px_total - 11 && n < 5000) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("reached_load_next", {31'd0, n < 5000}, 1);
      nreset = 1'b0;
      #1;
      check_zero_outputs("midframe_reset");
      px_before = px_count;
      exp_addr.delete();
      exp_res_addr.delete();
      exp_res_px.delete();
      repeat (2) @(negedge clk);
      nreset = 1'b1;
      repeat (8) @(negedge clk);
      check("no_px_after_reset", px_count, px_before);
      check("no_done_after_reset", done_count, 0);
      check("idle_after_reset", {31'd0, busy}, 0);
      run_frame(3, 3);
      for (int i = 0; i < 4; i++) run_frame($urandom_range(1, 7), $urandom_range(1, 7));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/sobel_scan_sequencer.md
SOBEL_SCAN_SEQUENCER -- requirements
Module: sobel_scan_sequencer

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  PIXEL_WIDTH  8   pixel data width
  DIM_BITS     8   width of image dimension inputs
  ADDR_BITS    16  frame-memory word address width
REQ-002 Ports, one per line: name  direction  width  meaning.
  clk_i         in   1            clock, rising edge
  nreset_i      in   1            asynchronous active-low reset
  start_i       in   1            frame start request, sampled in IDLE only
  img_width_i   in   DIM_BITS     image width W, sampled at start
  img_height_i  in   DIM_BITS     image height H, sampled at start
  mem_req_o     out  1            single-cycle read request pulse
  mem_addr_o    out  ADDR_BITS    read address, valid with mem_req_o
  mem_rvalid_i  in   1            read data valid, any latency >= 1 cycle
  mem_rdata_i   in   PIXEL_WIDTH  read data
  start_sobel_o out  1            window-engine enable, high during a strip
  px_o          out  PIXEL_WIDTH  pixel to window engine
  px_rdy_o      out  1            pixel strobe, single-cycle
  sobel_px_i    in   PIXEL_WIDTH  filtered pixel from window engine
  sobel_rdy_i   in   1            filtered pixel strobe
  res_px_o      out  PIXEL_WIDTH  result pixel
  res_addr_o    out  ADDR_BITS    result address (window centre)
  res_valid_o   out  1            result strobe, single-cycle
  busy_o        out  1            high from accepted start until done
  done_o        out  1            single-cycle end-of-frame pulse
REQ-003 Reset nreset_i is asynchronous, active-low; clock is clk_i.

Function
REQ-004 Scan order SHALL be column strips x = 0..W-3, and within each strip window top row y = 0..H-3.
REQ-005 The first window of a strip SHALL read 9 pixels row-major: (x,y),(x+1,y),(x+2,y), then rows y+1 and y+2; address = row*W + col.
REQ-006 Each subsequent window in the strip SHALL read only the 3 pixels of new row y+2, in order x, x+1, x+2.
REQ-007 At most one read SHALL be outstanding; the next mem_req_o SHALL be issued no earlier than the cycle after mem_rvalid_i.
REQ-008 On mem_rvalid_i, px_o SHALL be registered from mem_rdata_i and px_rdy_o pulsed high on the following cycle.
REQ-009 States: IDLE, LOAD_FIRST (9 reads), LOAD_NEXT (3 reads), WAIT_RES, STRIP_GAP, DONE.
REQ-010 IDLE->LOAD_FIRST on start_i when W>=3 and H>=3; IDLE->DONE on start_i when W<3 or H<3, with no memory reads.
REQ-011 LOAD_FIRST/LOAD_NEXT->WAIT_RES after the last pixel strobe of the window.
REQ-012 WAIT_RES on sobel_rdy_i: res_px_o <= sobel_px_i, res_addr_o <= (y+1)*W + (x+1), res_valid_o pulsed the next cycle; then ->LOAD_NEXT if y < H-3, ->STRIP_GAP if y = H-3 and x < W-3, else ->DONE.
REQ-013 start_sobel_o SHALL be high in LOAD_FIRST, LOAD_NEXT and WAIT_RES, and low in all other states.
REQ-014 STRIP_GAP SHALL hold start_sobel_o low for exactly 2 cycles, advance x by 1, reset y to 0, then ->LOAD_FIRST.
REQ-015 DONE SHALL pulse done_o for 1 cycle, then ->IDLE; busy_o is low only in IDLE.
REQ-016 start_i while busy_o is high SHALL be ignored; W and H are latched only on an accepted start.
REQ-017 sobel_rdy_i outside WAIT_RES SHALL be ignored; mem_rvalid_i with no outstanding request SHALL be ignored.
REQ-018 Address arithmetic SHALL be ADDR_BITS wide, unsigned, truncating; frames with H*W > 2^ADDR_BITS are unsupported.

Reset
REQ-019 Reset SHALL force state IDLE, all counters to 0, and all outputs to 0, including mem_addr_o, px_o, res_px_o and res_addr_o.
REQ-020 Reset mid-frame SHALL abandon the frame; no done_o is issued, and any read data arriving after reset is ignored.

Verification
REQ-021 W=3, H=3, memory latency 1 -> reads addresses 0..8 in order, one result res_addr=4, done_o, 9 px_rdy_o pulses.
REQ-022 W=4, H=3 -> strip0 reads 0,1,2,4,5,6,8,9,10 -> res 5; start_sobel_o low 2 cycles; strip1 reads 1,2,3,5,6,7,9,10,11 -> res 6; done.
REQ-023 W=3, H=4 -> reads 0..8, res 4, then reads 9,10,11, res 7, start_sobel_o high throughout, done.
REQ-024 W=2, H=5 -> done_o pulses within 2 cycles, no mem_req_o, no px_rdy_o.
REQ-025 Random memory latency 1-5 cycles with W=5, H=5 -> never more than 1 outstanding read; 9 results at centres 6,11,16,7,12,17,8,13,18, matching a golden Sobel model.
REQ-026 nreset_i asserted during a LOAD_NEXT read -> all outputs 0 immediately; a new start_i then rescans from address 0.
